// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the RAM arbiter slice.
package ram_arb_pkg;

    // Arbiter life cycle: INIT after reset (optional clear sweep), then RUN.
    typedef logic [0:0] ram_arb_state_t;
    localparam ram_arb_state_t ARB_INIT = 1'b0;
    localparam ram_arb_state_t ARB_RUN  = 1'b1;

    // Cycles from command acceptance to read data on the response port.
    localparam int RSP_LATENCY = 2;

    // Width of a requester index; never narrower than one bit.
    function automatic int req_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side command/response bus of the RAM arbiter.
interface ram_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_arbiter_rr_arbiter.sv
// Round-robin grant: the first requesting slot after the pointer wins.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = req_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index
);

    logic [ID_W-1:0] slot;
    logic            found;

    // Scan slots ptr+1, ptr+2, ... cyclically and grant the first valid one.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            slot = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (enable && !found && req[slot]) begin
                found       = 1'b1;
                grant[slot] = 1'b1;
                index       = slot;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between NUM_REQ requesters with
// round-robin grant and ID-tagged read responses.
// Optional macro RAM_ARB_INIT_EN: sweep INIT_VALUE into every word after reset.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    NUM_REQ    = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  init_done
);

    localparam int ID_W = req_id_w(NUM_REQ);

    ram_arb_state_t        state;
    logic [ID_W-1:0]       ptr;
    logic [ID_W-1:0]       grant_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [RSP_LATENCY-1:0] rd_pipe;
    logic [ID_W-1:0]       id_pipe [RSP_LATENCY];
`ifdef RAM_ARB_INIT_EN
    logic [ADDR_WIDTH:0]   init_cnt;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .enable (state == ARB_RUN),
        .grant  (grant),
        .index  (grant_idx)
    );

    assign bus.req_ready = grant;
    assign accept        = |grant;
    assign init_done     = (state == ARB_RUN);
    assign bus.rsp_data  = ram_q;

    // Pick the granted requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Life cycle: leave INIT once the optional sweep has covered every word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_INIT;
`ifdef RAM_ARB_INIT_EN
            init_cnt <= '0;
`endif
        end else if (state == ARB_INIT) begin
`ifdef RAM_ARB_INIT_EN
            if (init_cnt[ADDR_WIDTH]) begin
                state <= ARB_RUN;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
`else
            state <= ARB_RUN;
`endif
        end
    end

    // Register the RAM command: sweep writes during INIT, accepted commands in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else if (state == ARB_INIT) begin
`ifdef RAM_ARB_INIT_EN
            if (!init_cnt[ADDR_WIDTH]) begin
                ram_we   <= 1'b1;
                ram_addr <= init_cnt[ADDR_WIDTH-1:0];
                ram_data <= INIT_VALUE;
            end else begin
                ram_we <= 1'b0;
            end
`else
            ram_we <= 1'b0;
`endif
        end else if (accept) begin
            ram_we   <= sel_we;
            ram_addr <= sel_addr;
            ram_data <= sel_wdata;
        end else begin
            ram_we <= 1'b0;
        end
    end

    // Round-robin pointer follows the last accepted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

    // Track read ownership alongside the RAM's address/read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe <= '0;
            for (int i = 0; i < RSP_LATENCY; i++) begin
                id_pipe[i] <= '0;
            end
        end else begin
            rd_pipe    <= {rd_pipe[RSP_LATENCY-2:0], accept & ~sel_we};
            id_pipe[0] <= grant_idx;
            for (int i = 1; i < RSP_LATENCY; i++) begin
                id_pipe[i] <= id_pipe[i-1];
            end
        end
    end

    // Steer the read strobe to the requester that issued the read.
    always_comb begin
        bus.rsp_valid = '0;
        if (rd_pipe[RSP_LATENCY-1]) begin
            bus.rsp_valid[id_pipe[RSP_LATENCY-1]] = 1'b1;
        end
    end

endmodule
